multicycle_stall_unit: RTL
==========================

// Module: multicycle_stall_unit
// PURPOSE
// - Generalised EX-stage stall generator for multi-cycle functional units (MUL/DIV/REM IPs, fixed latency).
// - Per-op-class latency table; holds the pipeline from the issue cycle until the unit's result is valid.
// - Signals completion with a done pulse.
// - Extends the single-class divider stall with the following features:
//   - external-hold handshake
//   - synchronous flush
//   - saturating stall-cycle performance counter
// - Sits beside the hazard unit; its stall output is ORed into the global pipeline stall.
// PARAMETERS
// - NUM_OPS    3                      number of op classes (>=1)
// - LAT_W      5                      width of one latency entry; latency range 0..2^LAT_W-1
// - LATENCIES  {5'd10,5'd10,5'd3}     packed table, entry k = bits [k*LAT_W +: LAT_W] (MUL=3, DIV=10, REM=10)
// - PERF_W     32                     width of the performance counter
// PORTS
// - clk          in   1                  single clock, rising edge
// - rst          in   1                  asynchronous, active-high reset
// - issue_valid  in   1                  EX holds a multi-cycle instruction this cycle
// - issue_op     in   OP_W               op class index, OP_W = max(1,$clog2(NUM_OPS))
// - pipe_hold    in   1                  another stall source is freezing EX this cycle
// - flush        in   1                  kill the EX instruction (branch mispredict/trap)
// - stall        out  1                  freeze IF..EX
// - done         out  1                  result valid; EX instruction may retire
// - busy_op      out  OP_W               class of the in-flight op (0 when IDLE)
// - stall_cycles out  PERF_W             saturating count of cycles with stall=1
// BEHAVIOUR
// - Reset (async, any time, mid-operation included):
//   - state=IDLE, cnt=0, busy_op=0, stall_cycles=0.
//   - stall=0 and done=0 while rst is high.
// - Lookup: L = LATENCIES[issue_op].
//   - issue_op >= NUM_OPS gives L=0.
//   - L=0 means single-cycle: no stall and no done.
// - States: IDLE, BUSY, DONE. cnt is LAT_W bits.
// - IDLE:
//   - stall = issue_valid & (L!=0) & ~flush (combinational, same cycle).
//   - When accepted: state<=BUSY, cnt<=L-1, busy_op<=issue_op.
//   - If L==1: state<=DONE directly.
// - BUSY:
//   - stall=1.
//   - cnt!=1: cnt<=cnt-1.
//   - cnt==1: state<=DONE.
//   - issue_valid and issue_op are ignored.
// - DONE:
//   - stall=0, done=1.
//   - pipe_hold=1: remain in DONE with done held; the same EX instruction must not re-trigger.
//   - pipe_hold=0: state<=IDLE.
// - Latency: an instruction with L>=1 sees exactly L cycles of stall=1, counting the issue cycle.
//   - done rises in cycle issue+L.
//   - EX advances at the end of the first DONE cycle that has pipe_hold=0.
// - Back-to-back: a new issue is accepted only in IDLE.
//   - This gives one idle cycle minimum between consecutive multi-cycle ops.
// - Flush: highest priority among the synchronous inputs.
//   - Any state: state<=IDLE, cnt<=0, busy_op<=0.
//   - stall and done are forced 0 in the flush cycle.
//   - An issue in the same cycle as flush is dropped.
// - pipe_hold has no effect in IDLE (issue still accepted) or BUSY (countdown continues).
// - Perf counter:
//   - stall_cycles increments on every cycle with stall=1.
//   - It saturates at all-ones and is not cleared by flush.
// - All outputs except stall and done are registered.
//   - stall and done are combinational from state, issue_valid, issue_op and flush.
// STRUCTURE
// - Package mcs_pkg holds:
//   - state encoding localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
//   - op class constants (OP_MUL=0, OP_DIV=1, OP_REM=2)
//   - default LAT_W and LATENCIES
// - One sub-module, sat_counter #(W): increment enable, async reset, saturation.
//   - Used for stall_cycles.
// - Top level contains the latency lookup, FSM and countdown.
// TESTING
// - DIV (op=1, L=10):
//   - Stimulus: issue_valid=1 at cycle 0, pipe_hold=0.
//   - Required: stall=1 in cycles 0..9, done=1 only in cycle 10, stall_cycles=10.
// - MUL (op=2? no: op=0, L=3) with hold:
//   - Stimulus: issue at cycle 0; pipe_hold=1 in cycles 3..5; issue_valid held high throughout.
//   - Required: stall in cycles 0..2; done in cycles 3..6; no re-trigger; IDLE at cycle 7.
// - Flush mid-op:
//   - Stimulus: DIV issued at cycle 0, flush at cycle 4.
//   - Required: stall=0 at cycle 4, done never asserts, new MUL at cycle 5 stalls cycles 5..7.
// - Async reset mid-op:
//   - Stimulus: rst asserted between edges during BUSY with cnt=6.
//   - Required: stall=0 and busy_op=0 immediately; stall_cycles=0.
// - Invalid / zero-latency class:
//   - Stimulus: issue_op=3 (>= NUM_OPS).
//   - Required: stall=0, done=0, state stays IDLE.
// - Saturation:
//   - Stimulus: PERF_W=4, run 2 DIVs (20 stall cycles).
//   - Required: stall_cycles=4'hF.

Source files
------------

// File: rtl/mcs_pkg.sv
// ---------------------------------------------------------------------------
// mcs_pkg
// Shared definitions for the multi-cycle stall unit:
//   - FSM state type (IDLE / BUSY / DONE)
//   - op-class indices for the MUL/DIV/REM functional units
//   - default latency-table geometry and contents
// ---------------------------------------------------------------------------
package mcs_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Op-class indices into the latency table
    localparam int OP_MUL = 0;
    localparam int OP_DIV = 1;
    localparam int OP_REM = 2;

    // Default table: entry k lives in bits [k*LAT_W +: LAT_W]
    localparam int                DEF_NUM_OPS   = 3;
    localparam int                DEF_LAT_W     = 5;
    localparam logic [14:0]       DEF_LATENCIES = {5'd10, 5'd10, 5'd3};

endpackage

// File: rtl/multicycle_stall_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_stall_unit_if
// Bundle between the EX stage (master) and the multi-cycle stall unit (slave).
//   issue_valid  : EX holds a multi-cycle instruction
//   issue_op     : op-class index of that instruction
//   pipe_hold    : another stall source freezes EX this cycle
//   flush        : kill the EX instruction
//   stall        : freeze IF..EX
//   done         : result valid, EX instruction may retire
//   busy_op      : class of the in-flight op (0 when idle)
//   stall_cycles : saturating count of stalled cycles
// ---------------------------------------------------------------------------
interface multicycle_stall_unit_if #(
    parameter int OP_W   = 2,
    parameter int PERF_W = 32
);
    logic              issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic              pipe_hold;
    logic              flush;
    logic              stall;
    logic              done;
    logic [OP_W-1:0]   busy_op;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output issue_valid, issue_op, pipe_hold, flush,
        input  stall, done, busy_op, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_op, pipe_hold, flush,
        output stall, done, busy_op, stall_cycles
    );
endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the count
//   i_inc   : add one this cycle
//   o_count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Increment unless already saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/multicycle_stall_unit.sv
// ---------------------------------------------------------------------------
// multicycle_stall_unit
// Holds the pipeline while a fixed-latency multi-cycle unit (MUL/DIV/REM)
// works, then raises done until EX is allowed to advance.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of multicycle_stall_unit_if (handshake, stall, done,
//         busy_op, stall_cycles)
// ---------------------------------------------------------------------------
module multicycle_stall_unit
    import mcs_pkg::*;
#(
    parameter int                         NUM_OPS   = DEF_NUM_OPS,
    parameter int                         LAT_W     = DEF_LAT_W,
    parameter logic [NUM_OPS*LAT_W-1:0]   LATENCIES = DEF_LATENCIES,
    parameter int                         PERF_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_stall_unit_if.slave  bus
);

    localparam int OP_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_next_cnt;
    logic [OP_W-1:0]  r_busy_op;
    logic [OP_W-1:0]  w_next_busy_op;
    logic [LAT_W-1:0] w_lat;
    logic             w_stall;
    logic             w_done;

    // Out-of-range op classes read as latency 0 (treated as single-cycle)
    always_comb begin
        w_lat = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (int'(bus.issue_op) == k) begin
                w_lat = LATENCIES[k*LAT_W +: LAT_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy_op <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_busy_op <= w_next_busy_op;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle issue
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_busy_op = r_busy_op;
        if (bus.flush) begin
            w_next_state   = IDLE;
            w_next_cnt     = '0;
            w_next_busy_op = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.issue_valid && (w_lat != '0)) begin
                        // The issue cycle is the first stall cycle, so count L-1 more
                        w_next_cnt     = w_lat - LAT_W'(1);
                        w_next_busy_op = bus.issue_op;
                        w_next_state   = (w_lat == LAT_W'(1)) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    w_next_cnt = r_cnt - LAT_W'(1);
                    if (r_cnt == LAT_W'(1)) begin
                        w_next_state = DONE;
                    end
                end
                DONE: begin
                    // Stay put while held so the same EX instruction cannot re-issue
                    if (!bus.pipe_hold) begin
                        w_next_state   = IDLE;
                        w_next_cnt     = '0;
                        w_next_busy_op = '0;
                    end
                end
                default: begin
                    w_next_state   = IDLE;
                    w_next_cnt     = '0;
                    w_next_busy_op = '0;
                end
            endcase
        end
    end

    // Output logic; reset and flush both mask stall/done immediately
    always_comb begin
        w_stall = 1'b0;
        w_done  = 1'b0;
        if (!rst && !bus.flush) begin
            case (r_state)
                IDLE:    w_stall = bus.issue_valid && (w_lat != '0);
                BUSY:    w_stall = 1'b1;
                DONE:    w_done  = 1'b1;
                default: w_stall = 1'b0;
            endcase
        end
    end

    sat_counter #(
        .W (PERF_W)
    ) u_perf (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall),
        .o_count (bus.stall_cycles)
    );

    assign bus.stall   = w_stall;
    assign bus.done    = w_done;
    assign bus.busy_op = r_busy_op;

endmodule
